// File: rtl/hwag_sched.sv
`default_nettype none
// ============================================================================
// Module   : hwag_sched
// Purpose  : Angle-driven output scheduler. Each of CH_NUM channels asserts
//            its output when the crank angle crosses its on-angle and
//            deasserts it when the angle crosses its off-angle. Crossings
//            are detected over the arc travelled since the previous cycle,
//            so tooth re-sync jumps and the TOP->0 wrap are handled.
// Ports    : clk, rst         clock, asynchronous active-high reset
//            i_hwag_start     angle generator synchronized (acnt valid)
//            i_acnt           current angle, 0..ANGLE_TOP
//            i_wr_ena         one-cycle host write strobe
//            i_wr_ch          target channel of the write
//            i_wr_en/on/off   channel enable, on-angle, off-angle
//            o_ch_out         channel outputs (decoded from state register)
//            o_ch_pend        write accepted but not yet committed
//            o_ch_miss        sticky skipped-pulse flag (HWAG_SCHED_MISS_EN)
// Options  : define HWAG_SCHED_MISS_EN to add o_ch_miss.
// Revision : 1.0 - initial release
// ============================================================================
module hwag_sched #(
   parameter int CH_NUM      = 4,
   parameter int ANGLE_WIDTH = 24,
   parameter int ANGLE_TOP   = 3839
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_hwag_start,
   input  logic [ANGLE_WIDTH-1:0]    i_acnt,
   input  logic                      i_wr_ena,
   input  logic [$clog2(CH_NUM)-1:0] i_wr_ch,
   input  logic                      i_wr_en,
   input  logic [ANGLE_WIDTH-1:0]    i_wr_on,
   input  logic [ANGLE_WIDTH-1:0]    i_wr_off,
   output logic [CH_NUM-1:0]         o_ch_out,
   output logic [CH_NUM-1:0]         o_ch_pend
`ifdef HWAG_SCHED_MISS_EN
   ,
   output logic [CH_NUM-1:0]         o_ch_miss
`endif
);

   localparam int                   c_CW   = $clog2(CH_NUM);
   localparam logic [ANGLE_WIDTH:0] c_MOD  = (ANGLE_WIDTH+1)'(ANGLE_TOP + 1);
   localparam logic [ANGLE_WIDTH:0] c_HALF = (ANGLE_WIDTH+1)'((ANGLE_TOP + 1) / 2);
   localparam logic [ANGLE_WIDTH-1:0] c_TOP = ANGLE_WIDTH'(ANGLE_TOP);

   localparam logic [1:0] c_S_IDLE   = 2'd0;
   localparam logic [1:0] c_S_WAIT   = 2'd1;
   localparam logic [1:0] c_S_ACTIVE = 2'd2;

   // Forward distance from b to a around the revolution.
   function automatic logic [ANGLE_WIDTH:0] f_fwd(input logic [ANGLE_WIDTH-1:0] a,
                                                  input logic [ANGLE_WIDTH-1:0] b);
      if (a >= b) return {1'b0, a} - {1'b0, b};
      else        return {1'b0, a} + c_MOD - {1'b0, b};
   endfunction

   logic [ANGLE_WIDTH-1:0] r_prev_angle;
   logic                   r_prev_valid;
   logic [ANGLE_WIDTH:0]   w_step;
   logic                   w_eval;
   logic                   w_wr_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev_angle <= '0;
         r_prev_valid <= 1'b0;
      end else begin
         r_prev_angle <= i_acnt;
         r_prev_valid <= i_hwag_start;
      end
   end

   // A step larger than half a revolution is a backward jump: no crossings.
   assign w_step  = f_fwd(i_acnt, r_prev_angle);
   assign w_eval  = i_hwag_start && r_prev_valid && (w_step != '0) && (w_step <= c_HALF);
   assign w_wr_ok = i_wr_ena && (i_wr_on <= c_TOP) && (i_wr_off <= c_TOP);

   genvar gi;
   generate
      for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
         localparam logic [c_CW-1:0] c_IDX = c_CW'(gi);

         logic [1:0]             r_state;
         logic [1:0]             w_xn;
         logic [1:0]             w_nxt;
         logic                   r_pend;
         logic                   r_cfg_en;
         logic                   r_sh_en;
         logic [ANGLE_WIDTH-1:0] r_cfg_on;
         logic [ANGLE_WIDTH-1:0] r_cfg_off;
         logic [ANGLE_WIDTH-1:0] r_sh_on;
         logic [ANGLE_WIDTH-1:0] r_sh_off;
         logic                   w_hit;
         logic                   w_has;
         logic                   w_commit;
         logic                   w_leave;
         logic                   w_sh_en;
         logic [ANGLE_WIDTH-1:0] w_sh_on;
         logic [ANGLE_WIDTH-1:0] w_sh_off;
         logic                   w_en_eff;
         logic [ANGLE_WIDTH-1:0] w_on_eff;
         logic [ANGLE_WIDTH-1:0] w_off_eff;
         logic [ANGLE_WIDTH:0]   w_d_on;
         logic [ANGLE_WIDTH:0]   w_d_off;
         logic                   w_x_on;
         logic                   w_x_off;
         logic                   w_act;

         // Incoming write bypasses the shadow so a commit can use it at once.
         assign w_hit    = w_wr_ok && (i_wr_ch == c_IDX);
         assign w_sh_en  = w_hit ? i_wr_en  : r_sh_en;
         assign w_sh_on  = w_hit ? i_wr_on  : r_sh_on;
         assign w_sh_off = w_hit ? i_wr_off : r_sh_off;
         assign w_has    = w_hit || r_pend;

         assign w_d_on  = f_fwd(r_cfg_on,  r_prev_angle);
         assign w_d_off = f_fwd(r_cfg_off, r_prev_angle);
         assign w_x_on  = w_eval && (w_d_on  != '0) && (w_d_on  <= w_step);
         assign w_x_off = w_eval && (w_d_off != '0) && (w_d_off <= w_step);

         // State register
         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_state <= c_S_IDLE;
            else     r_state <= w_nxt;
         end

         // Next-state logic, including commit decision
         always_comb begin
            w_xn = c_S_IDLE;
            case (r_state)
               c_S_IDLE:   w_xn = c_S_WAIT;
               c_S_WAIT,
               c_S_ACTIVE: begin
                  // Both edges in one step: whichever lies further along wins.
                  if (w_x_on && w_x_off)  w_xn = (w_d_on > w_d_off) ? c_S_ACTIVE : c_S_WAIT;
                  else if (w_x_on)        w_xn = c_S_ACTIVE;
                  else if (w_x_off)       w_xn = c_S_WAIT;
                  else                    w_xn = r_state;
               end
               default:    w_xn = c_S_IDLE;
            endcase

            w_leave  = (r_state == c_S_ACTIVE) && (!i_hwag_start || (w_xn != c_S_ACTIVE));
            // A disable write commits even mid-pulse.
            w_commit = w_has && ((r_state != c_S_ACTIVE) || w_leave || (w_hit && !i_wr_en));

            w_en_eff  = w_commit ? w_sh_en  : r_cfg_en;
            w_on_eff  = w_commit ? w_sh_on  : r_cfg_on;
            w_off_eff = w_commit ? w_sh_off : r_cfg_off;

            if (!i_hwag_start || !w_en_eff || (w_on_eff == w_off_eff)) w_nxt = c_S_IDLE;
            else                                                       w_nxt = w_xn;
         end

         // Output decode
         always_comb begin
            w_act = (r_state == c_S_ACTIVE);
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_pend    <= 1'b0;
               r_sh_en   <= 1'b0;
               r_sh_on   <= '0;
               r_sh_off  <= '0;
               r_cfg_en  <= 1'b0;
               r_cfg_on  <= '0;
               r_cfg_off <= '0;
            end else begin
               r_pend   <= w_has && !w_commit;
               r_sh_en  <= w_sh_en;
               r_sh_on  <= w_sh_on;
               r_sh_off <= w_sh_off;
               if (w_commit) begin
                  r_cfg_en  <= w_sh_en;
                  r_cfg_on  <= w_sh_on;
                  r_cfg_off <= w_sh_off;
               end
            end
         end

         assign o_ch_out[gi]  = w_act;
         assign o_ch_pend[gi] = r_pend;

`ifdef HWAG_SCHED_MISS_EN
         logic r_miss;
         logic w_miss;

         // Pulse skipped: waiting, and on then off both passed in one step.
         assign w_miss = (r_state == c_S_WAIT) && w_x_on && w_x_off && (w_d_off > w_d_on);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_miss <= 1'b0;
            end else begin
               if (w_commit) r_miss <= 1'b0;
               if (w_miss)   r_miss <= 1'b1;
            end
         end

         assign o_ch_miss[gi] = r_miss;
`endif
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hwag_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwag_sched
// Purpose  : Self-checking bench for hwag_sched. A reference model walks the
//            arc between consecutive angles to find on/off events and tracks
//            the shadow/commit rules per channel.
// Options  : HWAG_SCHED_MISS_EN also checks o_ch_miss.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwag_sched;
   localparam int CH_NUM = 4;
   localparam int AW     = 24;
   localparam int TOP    = 3839;
   localparam int M      = TOP + 1;
   localparam int CW     = $clog2(CH_NUM);

   logic              clk = 1'b0;
   logic              rst;
   logic              hwag_start;
   logic [AW-1:0]     acnt;
   logic              wr_ena;
   logic [CW-1:0]     wr_ch;
   logic              wr_en;
   logic [AW-1:0]     wr_on;
   logic [AW-1:0]     wr_off;
   logic [CH_NUM-1:0] ch_out;
   logic [CH_NUM-1:0] ch_pend;
`ifdef HWAG_SCHED_MISS_EN
   logic [CH_NUM-1:0] ch_miss;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hwag_sched #(.CH_NUM(CH_NUM), .ANGLE_WIDTH(AW), .ANGLE_TOP(TOP)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_hwag_start (hwag_start),
      .i_acnt       (acnt),
      .i_wr_ena     (wr_ena),
      .i_wr_ch      (wr_ch),
      .i_wr_en      (wr_en),
      .i_wr_on      (wr_on),
      .i_wr_off     (wr_off),
      .o_ch_out     (ch_out),
      .o_ch_pend    (ch_pend)
`ifdef HWAG_SCHED_MISS_EN
      ,
      .o_ch_miss    (ch_miss)
`endif
   );

   // ---------------- reference model ----------------
   int m_prev;
   bit m_pv;
   bit m_arm  [CH_NUM];   // channel scheduled (waiting or active)
   bit m_act  [CH_NUM];
   bit m_pend [CH_NUM];
   bit m_miss [CH_NUM];
   bit m_cen  [CH_NUM];
   int m_con  [CH_NUM];
   int m_coff [CH_NUM];
   bit m_sen  [CH_NUM];
   int m_son  [CH_NUM];
   int m_soff [CH_NUM];

   task automatic model_reset();
      m_prev = 0;
      m_pv   = 0;
      for (int c = 0; c < CH_NUM; c++) begin
         m_arm[c] = 0; m_act[c] = 0; m_pend[c] = 0; m_miss[c] = 0;
         m_cen[c] = 0; m_con[c] = 0; m_coff[c] = 0;
         m_sen[c] = 0; m_son[c] = 0; m_soff[c] = 0;
      end
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      int step;
      bit eval;
      step = ((int'(acnt) - m_prev) % M + M) % M;
      eval = hwag_start && m_pv && (step != 0) && (step <= M / 2);
      for (int c = 0; c < CH_NUM; c++) begin
         bit hit, has, na, saw_on, missed, commit, leaving, valid;
         int a;
         hit = wr_ena && (int'(wr_ch) == c) && (int'(wr_on) <= TOP) && (int'(wr_off) <= TOP);
         if (hit) begin
            m_sen[c] = wr_en; m_son[c] = int'(wr_on); m_soff[c] = int'(wr_off);
         end
         has    = hit || m_pend[c];
         na     = m_act[c];
         saw_on = 0;
         if (m_arm[c] && eval) begin
            for (int k = 1; k <= step; k++) begin
               a = (m_prev + k) % M;
               if (a == m_con[c])  begin na = 1; saw_on = 1; end
               if (a == m_coff[c]) na = 0;
            end
         end
         missed = m_arm[c] && !m_act[c] && saw_on && !na;
         if (!hwag_start) na = 0;
         leaving = m_act[c] && !na;
         commit  = has && (!m_act[c] || leaving || (hit && !wr_en));
         if (commit) begin
            m_cen[c] = m_sen[c]; m_con[c] = m_son[c]; m_coff[c] = m_soff[c];
         end
         m_pend[c] = has && !commit;
         if (commit) m_miss[c] = 0;
         if (missed) m_miss[c] = 1;
         valid = m_cen[c] && (m_con[c] != m_coff[c]);
         if (!hwag_start || !valid) begin
            m_arm[c] = 0; m_act[c] = 0;
         end else if (!m_arm[c]) begin
            m_arm[c] = 1; m_act[c] = 0;
         end else begin
            m_act[c] = na;
         end
      end
      m_pv   = hwag_start;
      m_prev = int'(acnt);
   endtask

   function automatic logic [31:0] vec(input int sel);
      logic [31:0] v;
      v = '0;
      for (int c = 0; c < CH_NUM; c++)
         v[c] = (sel == 0) ? m_act[c] : (sel == 1) ? m_pend[c] : m_miss[c];
      return v;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t acnt=%0d)", tag, obs, exp, $time, acnt);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("ch_out",  32'(ch_out),  vec(0));
      chk("ch_pend", 32'(ch_pend), vec(1));
`ifdef HWAG_SCHED_MISS_EN
      chk("ch_miss", 32'(ch_miss), vec(2));
`endif
   endtask

   task automatic adv(input int d);
      acnt = AW'((int'(acnt) + d) % M);
   endtask

   task automatic ramp_to(input int t);
      while (int'(acnt) != t) begin
         adv(1);
         tick();
      end
   endtask

   task automatic wr(input int ch, input bit en, input int on, input int off);
      wr_ena = 1'b1; wr_ch = CW'(ch); wr_en = en; wr_on = AW'(on); wr_off = AW'(off);
      adv(1);
      tick();
      wr_ena = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, on, w;
      rst = 1'b1; hwag_start = 1'b0; acnt = '0;
      wr_ena = 1'b0; wr_ch = '0; wr_en = 1'b0; wr_on = '0; wr_off = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out",  32'(ch_out),  32'd0);
      chk("reset_pend", 32'(ch_pend), 32'd0);
`ifdef HWAG_SCHED_MISS_EN
      chk("reset_miss", 32'(ch_miss), 32'd0);
`endif
      rst = 1'b0;
      hwag_start = 1'b1;
      tick();

      // Configure all channels while idle: commits immediately.
      wr(0, 1, 128, 256);
      chk("pend_immediate", 32'(ch_pend[0]), 32'd0);
      wr(1, 1, 3800, 40);
      wr(2, 1, 500, 600);
      wr(3, 1, 1020, 1080);

      ramp_to(127);  chk("ch0_before_on", 32'(ch_out[0]), 32'd0);
      ramp_to(128);  chk("ch0_rise",      32'(ch_out[0]), 32'd1);
      ramp_to(255);  chk("ch0_hold",      32'(ch_out[0]), 32'd1);
      ramp_to(256);  chk("ch0_fall",      32'(ch_out[0]), 32'd0);

      // Rewrite ch2 mid-pulse: held pending until the pulse ends.
      ramp_to(549);  chk("ch2_active",    32'(ch_out[2]), 32'd1);
      wr(2, 1, 700, 800);
      chk("ch2_pending",   32'(ch_pend[2]), 32'd1);
      ramp_to(599);  chk("ch2_still_pend", 32'(ch_pend[2]), 32'd1);
      ramp_to(600);  chk("ch2_commit",     32'(ch_pend[2]), 32'd0);
      chk("ch2_old_fall", 32'(ch_out[2]), 32'd0);
      ramp_to(700);  chk("ch2_new_rise",  32'(ch_out[2]), 32'd1);
      ramp_to(800);  chk("ch2_new_fall",  32'(ch_out[2]), 32'd0);

      // Jump over a whole pulse.
      ramp_to(1000);
      acnt = AW'(1100);
      tick();
      chk("ch3_skipped", 32'(ch_out[3]), 32'd0);
`ifdef HWAG_SCHED_MISS_EN
      chk("ch3_miss", 32'(ch_miss[3]), 32'd1);
`endif

      // Wrap-around pulse.
      ramp_to(3799); chk("ch1_before",    32'(ch_out[1]), 32'd0);
      ramp_to(3800); chk("ch1_rise",      32'(ch_out[1]), 32'd1);
      ramp_to(39);   chk("ch1_over_wrap", 32'(ch_out[1]), 32'd1);
      ramp_to(40);   chk("ch1_fall",      32'(ch_out[1]), 32'd0);

      // Loss of sync mid-pulse, then restore after the on-angle.
      ramp_to(200);  chk("ch0_active_200", 32'(ch_out[0]), 32'd1);
      hwag_start = 1'b0;
      adv(1);
      tick();
      chk("ch0_sync_lost", 32'(ch_out[0]), 32'd0);
      repeat (5) begin adv(1); tick(); end
      hwag_start = 1'b1;
      acnt = AW'(300);
      tick();
      ramp_to(127);  chk("ch0_no_out_resync", 32'(ch_out[0]), 32'd0);
      ramp_to(128);  chk("ch0_rise_resync",   32'(ch_out[0]), 32'd1);

      // Disable write to an active channel drops the output next cycle.
      ramp_to(150);
      wr(0, 0, 128, 256);
      chk("ch0_disable", 32'(ch_out[0]), 32'd0);
      chk("ch0_disable_pend", 32'(ch_pend[0]), 32'd0);

      // Out-of-range write is ignored.
      wr(1, 1, 4000, 10);
      chk("oor_ignored_pend", 32'(ch_pend[1]), 32'd0);

      // Asynchronous reset mid-pulse with a write pending.
      ramp_to(750);
      wr(2, 1, 900, 950);
      chk("ch2_pend_before_rst", 32'(ch_pend[2]), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_rst_out",  32'(ch_out),  32'd0);
      chk("async_rst_pend", 32'(ch_pend), 32'd0);
      model_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      acnt = '0;
      tick();

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3)       acnt = AW'($urandom_range(0, TOP));
         else if (r < 8)  adv(int'($urandom_range(2, 200)));
         else             adv(int'($urandom_range(0, 12)));
         if (!hwag_start) hwag_start = ($urandom_range(0, 4) == 0);
         else if (r == 99) hwag_start = 1'b0;
         if ($urandom_range(0, 24) == 0) begin
            on = int'($urandom_range(0, TOP));
            w  = int'($urandom_range(0, 600));
            wr_ena = 1'b1;
            wr_ch  = CW'($urandom_range(0, CH_NUM - 1));
            wr_en  = ($urandom_range(0, 4) != 0);
            wr_on  = AW'(on);
            wr_off = ($urandom_range(0, 15) == 0) ? AW'(4096) : AW'((on + w) % M);
         end
         tick();
         wr_ena = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hwag_sched.md
Name: hwag_sched

Overview:
- Angle-driven output scheduler for the angle generator.
- Takes the synchronized crank angle counter (acnt, 0..3839 per revolution, 64 units per tooth) and the sync flag (hwag_start).
- Drives CH_NUM output channels (coil/injector drive). Each channel asserts at a programmed on-angle and deasserts at a programmed off-angle.
- Sits between hwag_core and the pin drivers. Configured by the host through a single-channel write port with shadow/commit handling.

Parameters:
CH_NUM, 4, number of output channels (2..8)
ANGLE_WIDTH, 24, width of acnt and angle registers
ANGLE_TOP, 3839, last angle value of a revolution; modulus is ANGLE_TOP+1

Ports:
clk  in  1  module clock
rst  in  1  asynchronous reset, active-high
hwag_start  in  1  angle generator synchronized; acnt valid while 1
acnt  in  ANGLE_WIDTH  current angle from hwag_core
wr_ena  in  1  one-cycle write strobe
wr_ch  in  $clog2(CH_NUM)  target channel of write
wr_en  in  1  channel enable carried with write
wr_on  in  ANGLE_WIDTH  on-angle, 0..ANGLE_TOP
wr_off  in  ANGLE_WIDTH  off-angle, 0..ANGLE_TOP
ch_out  out  CH_NUM  registered channel outputs
ch_pend  out  CH_NUM  1 = write accepted but not yet committed for that channel

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: ch_out=0, ch_pend=0, all channels IDLE, all angle/shadow registers 0, prev_angle=0, prev_valid=0.
- Step tracking:
  - prev_valid is set on the first clk after hwag_start=1; prev_angle<=acnt every clk.
  - While hwag_start=1 and prev_valid=1, each cycle computes:
    - step = (acnt - prev_angle) mod (ANGLE_TOP+1)
    - dist_x = (target_x - prev_angle) mod (ANGLE_TOP+1), for target on/off of each channel
  - Crossing of target x: step!=0 and dist_x!=0 and dist_x<=step. This covers angle jumps from tooth re-sync loads and wrap 3839->0.
  - step > (ANGLE_TOP+1)/2 is treated as a backward jump: no crossings that cycle.
- Per-channel FSM, states IDLE, WAIT_ON, ACTIVE:
  - IDLE: output 0. Goes to WAIT_ON on commit with en=1 and on!=off.
  - WAIT_ON: output 0. Goes to ACTIVE on on-crossing.
  - ACTIVE: output 1. Goes to WAIT_ON on off-crossing.
  - Both on and off crossed in one step:
    - dist_off > dist_on: pulse skipped, stay/return WAIT_ON (miss).
    - dist_on > dist_off: end in ACTIVE.
  - on==off or en=0: channel held IDLE.
- Output latency: ch_out changes on the clk edge that samples the crossing acnt value, i.e. 1 cycle after acnt reaches the target.
- Write/commit rules:
  - wr_ena latches {wr_en,wr_on,wr_off} into the channel shadow and sets ch_pend.
  - Commit occurs when the channel is not ACTIVE. The same cycle as the write is allowed, so ch_pend then stays 0.
  - Commit can also occur on the cycle the channel leaves ACTIVE. The new values apply from the next cycle.
  - A second write while pending overwrites the shadow.
  - A write with wr_en=0 commits immediately in any state and forces ch_out low the next cycle.
  - wr_on/wr_off > ANGLE_TOP: write ignored, ch_pend unchanged.
- Loss of sync (hwag_start=0):
  - All channels go to IDLE-equivalent hold with ch_out=0, and prev_valid clears.
  - Committed configs are retained. Channels with en=1 re-enter WAIT_ON when hwag_start returns; first crossing is evaluated from the second cycle.
- Pending commits still occur while unsynced (channel not ACTIVE).

Optional Feature:
- HWAG_SCHED_MISS_EN, when defined:
  - Adds output ch_miss [CH_NUM] (reset 0), set sticky when a channel's pulse is skipped (both crossings in one step with off later).
  - Cleared by a committed write to that channel.
- When undefined: port and logic absent; skipped pulses are silently dropped.

Test Plan:
- Ch0 on=128 off=256, acnt ramps 0..3839 by 1 per clk -> ch_out[0] rises on the cycle after acnt=128, falls on the cycle after acnt=256, repeats every revolution.
- Ch1 on=3800 off=40 (wrap) -> ch_out[1] high from acnt 3800 through wrap to 40. Width 80 angle units.
- Ch2 on=500 off=600 while ACTIVE, write on=700 off=800 at acnt=550 -> ch_pend[2]=1 until acnt=600, pulse ends at 600, next pulse 700..800, ch_pend[2]=0.
- acnt jumps 1000->1100 in one clk with ch3 on=1020 off=1080 -> ch_out[3] stays 0. With HWAG_SCHED_MISS_EN, ch_miss[3]=1.
- Ch0 ACTIVE at acnt=200 (on=128 off=256), drop hwag_start -> ch_out[0]=0 next clk. Restore at acnt=300 -> no output until next acnt=128.
- rst asserted mid-pulse -> ch_out, ch_pend immediately 0. With wr_en=0 write to an active channel, output drops the next cycle.
